// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus bundle: fetch port, data port and memory port.
// Latency: n/a (signal bundle only).
// Backpressure: requesters hold x_cs while x_stall is high; memory completes with m_ack.
interface mem_arbiter_if;
  logic        i_cs;
  logic [31:0] i_addr;
  logic [31:0] i_dout;
  logic        i_stall;
  logic        d_cs;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_din;
  logic [31:0] d_dout;
  logic        d_stall;
  logic        m_cs;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] m_dout;
  logic        m_ack;

  // Arbiter side: consumes requests and memory responses, drives memory requests.
  modport slave (
    input  i_cs, i_addr, d_cs, d_we, d_addr, d_din, m_dout, m_ack,
    output i_dout, i_stall, d_dout, d_stall, m_cs, m_we, m_addr, m_din
  );

  // Environment side: requesters plus the memory.
  modport master (
    output i_cs, i_addr, d_cs, d_we, d_addr, d_din, m_dout, m_ack,
    input  i_dout, i_stall, d_dout, d_stall, m_cs, m_we, m_addr, m_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory, with per-grant ack timeout.
// Latency: one cycle IDLE decision, memory latency, one RELEASE cycle; data returned combinationally on m_ack.
// Backpressure: x_stall holds the requester until its completion/timeout; ARB_RR_EN selects round-robin ties.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        m_cs_q, m_cs_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_din_q, m_din_d;
  logic        i_done, d_done;
  logic [31:0] i_dout_c, d_dout_c;
  logic        err_c;
  logic        pick_d;
  logic        prefer_d;

`ifdef ARB_RR_EN
  // 1 when data was the last port granted; reset means "instruction last".
  logic last_d_q;

  // Pointer follows every grant so a tie goes to the port not served last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b0;
    end else if (state_q == IDLE && (bus.i_cs || bus.d_cs)) begin
      last_d_q <= pick_d;
    end
  end

  assign prefer_d = ~last_d_q;
`else
  // Data always wins a tie so a MEM-stage access never waits behind fetch.
  assign prefer_d = 1'b1;
`endif

  // State and latched memory request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      m_cs_q   <= 1'b0;
      m_we_q   <= 1'b0;
      m_addr_q <= 32'd0;
      m_din_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_cs_q   <= m_cs_d;
      m_we_q   <= m_we_d;
      m_addr_q <= m_addr_d;
      m_din_q  <= m_din_d;
    end
  end

  // Arbitration, grant completion/timeout and the combinational return path.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_we_d   = m_we_q;
    m_addr_d = m_addr_q;
    m_din_d  = m_din_q;
    i_done   = 1'b0;
    d_done   = 1'b0;
    i_dout_c = 32'd0;
    d_dout_c = 32'd0;
    err_c    = 1'b0;
    pick_d   = bus.d_cs && (!bus.i_cs || prefer_d);

    case (state_q)
      IDLE: begin
        if (bus.i_cs || bus.d_cs) begin
          cnt_d = 8'd0;
          if (pick_d) begin
            state_d  = GRANT_D;
            m_we_d   = bus.d_we;
            m_addr_d = bus.d_addr;
            m_din_d  = bus.d_din;
          end else begin
            state_d  = GRANT_I;
            m_we_d   = 1'b0;
            m_addr_d = bus.i_addr;
            m_din_d  = 32'd0;
          end
        end
      end
      GRANT_I: begin
        if (bus.m_ack) begin
          i_done   = 1'b1;
          i_dout_c = bus.i_cs ? bus.m_dout : 32'd0;
          state_d  = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          i_done  = 1'b1;
          err_c   = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GRANT_D: begin
        if (bus.m_ack) begin
          d_done   = 1'b1;
          d_dout_c = bus.d_cs ? bus.m_dout : 32'd0;
          state_d  = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          d_done  = 1'b1;
          err_c   = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        // m_ack here is ignored; m_cs low lets the memory restart its latency.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    m_cs_d = (state_d == GRANT_I) || (state_d == GRANT_D);
  end

  assign bus.m_cs    = m_cs_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_din   = m_din_q;
  assign bus.i_dout  = i_dout_c;
  assign bus.d_dout  = d_dout_c;
  assign bus.i_stall = bus.i_cs && !i_done;
  assign bus.d_stall = bus.d_cs && !d_done;
  assign err         = err_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory model with programmable ack latency.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Checks reset, single fetch, tie, write hold, timeout, owner drop, reset mid-grant, tie order.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic err;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int mem_lat = 9;
  bit mem_en = 1'b1;
  bit keep_cs = 1'b0;
  int done_port[$];
  int done_cyc[$];
  logic [31:0] done_dat[$];
  int err_cnt;
  int err_at;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory contents: word n holds 0x1000_0000 + n*0x11.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2) * 32'h11;
  endfunction

  // Memory: acks in the mem_lat-th cycle that m_cs has been continuously high.
  initial begin
    int age;
    age = 0;
    bus.m_ack  = 1'b0;
    bus.m_dout = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_cs) age++;
      else age = 0;
      bus.m_ack  = mem_en && bus.m_cs && (age == mem_lat);
      bus.m_dout = (bus.m_ack && !bus.m_we) ? memw(bus.m_addr) : 32'd0;
    end
  end

  // Runs until ngr completions are seen; cycle 0 is the cycle this is entered.
  task automatic serve(input int maxc, input int ngr);
    int c;
    int got;
    bit di, dd;
    c = 0;
    got = 0;
    done_port.delete();
    done_cyc.delete();
    done_dat.delete();
    err_cnt = 0;
    err_at = -1;
    while (got < ngr && c < maxc) begin
      di = 1'b0;
      dd = 1'b0;
      @(negedge clk);
      if (err) begin
        err_cnt++;
        err_at = c;
      end
      if (bus.d_cs && !bus.d_stall) begin
        done_port.push_back(1); done_cyc.push_back(c); done_dat.push_back(bus.d_dout);
        got++; dd = 1'b1;
      end
      if (bus.i_cs && !bus.i_stall) begin
        done_port.push_back(0); done_cyc.push_back(c); done_dat.push_back(bus.i_dout);
        got++; di = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!keep_cs) begin
        if (dd) bus.d_cs = 1'b0;
        if (di) bus.i_cs = 1'b0;
      end
      c++;
    end
    if (got < ngr) chk("serve_bound", got, ngr);
    while (done_port.size() < ngr) begin
      done_port.push_back(-1); done_cyc.push_back(-1); done_dat.push_back(32'hxxxx_xxxx);
    end
  endtask

  // One cycle in which the memory request must be idle (RELEASE or IDLE).
  task automatic gap(input string tag);
    @(negedge clk);
    chk(tag, bus.m_cs, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad, mcs_n, cdone;
    logic [31:0] dout_w;
    rst = 1'b0;
    bus.i_cs = 1'b0; bus.i_addr = 32'd0;
    bus.d_cs = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_din = 32'd0;

    // Reset state
    @(negedge clk);
    chk("rst_m_cs", bus.m_cs, 1'b0);
    chk("rst_m_we", bus.m_we, 1'b0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_m_din", bus.m_din, 32'd0);
    chk("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single fetch, latency 9: stall 9 cycles, data on ack cycle, then RELEASE
    mem_lat = 9;
    bus.i_cs = 1'b1; bus.i_addr = 32'h4;
    serve(40, 1);
    chk("fetch_cyc", done_cyc[0], 9);
    chk("fetch_dat", done_dat[0], 32'h1000_0011);
    chk("fetch_err", err_cnt, 0);
    gap("fetch_rel_mcs");

    // Simultaneous requests: data first, fetch after data completion + RELEASE + IDLE
    mem_lat = 3;
    bus.d_cs = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    bus.i_cs = 1'b1; bus.i_addr = 32'h20;
    serve(40, 2);
    chk("tie_first_port", done_port[0], 1);
    chk("tie_d_cyc", done_cyc[0], 3);
    chk("tie_d_dat", done_dat[0], 32'h1000_0044);
    chk("tie_second_port", done_port[1], 0);
    chk("tie_i_cyc", done_cyc[1], 8);
    chk("tie_i_dat", done_dat[1], 32'h1000_0088);
    gap("tie_rel_mcs");

    // Write: latched request holds even when the requester changes addr/data
    mem_lat = 4;
    bus.d_cs = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_din = 32'hDEAD_BEEF;
    bad = 0; mcs_n = 0; cdone = -1; dout_w = 32'hFFFF_FFFF;
    for (int c = 0; c < 30 && cdone < 0; c++) begin
      @(negedge clk);
      if (bus.m_cs) begin
        mcs_n++;
        if (bus.m_we !== 1'b1 || bus.m_addr !== 32'h8 || bus.m_din !== 32'hDEAD_BEEF) bad++;
      end
      if (!bus.d_stall) begin
        cdone = c;
        dout_w = bus.d_dout;
      end
      @(posedge clk); #1;
      if (c == 1) begin
        bus.d_addr = 32'h100; bus.d_din = 32'h0;
      end
    end
    bus.d_cs = 1'b0; bus.d_we = 1'b0;
    chk("wr_cyc", cdone, 4);
    chk("wr_hold_bad", bad, 0);
    chk("wr_mcs_cycles", mcs_n, 4);
    chk("wr_dout", dout_w, 32'd0);
    gap("wr_rel_mcs");

    // Timeout: memory silent, err on 16th grant cycle with stall released, dout 0
    mem_en = 1'b0;
    bus.d_cs = 1'b1; bus.d_addr = 32'hC;
    serve(40, 1);
    chk("to_cyc", done_cyc[0], 16);
    chk("to_dat", done_dat[0], 32'd0);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_err_at", err_at, 16);
    @(negedge clk);
    chk("to_rel_mcs", bus.m_cs, 1'b0);
    chk("to_rel_err", err, 1'b0);
    @(posedge clk); #1;
    gap("to_idle_mcs");

    // Owner drops cs mid-grant: no stall, err still pulses at timeout
    bus.i_cs = 1'b1; bus.i_addr = 32'h40;
    bad = 0; err_cnt = 0; err_at = -1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (err) begin
        err_cnt++;
        err_at = c;
      end
      if (c >= 3 && (bus.i_stall !== 1'b0 || bus.i_dout !== 32'd0)) bad++;
      @(posedge clk); #1;
      if (c == 2) bus.i_cs = 1'b0;
    end
    chk("drop_err_cnt", err_cnt, 1);
    chk("drop_err_at", err_at, 16);
    chk("drop_bad", bad, 0);
    mem_en = 1'b1;

    // Reset in GRANT_I cycle 3, then a fresh grant with a fresh counter
    mem_lat = 9;
    bus.i_cs = 1'b1; bus.i_addr = 32'h4;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_mcs", bus.m_cs, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_rst_mcs", bus.m_cs, 1'b0);
    chk("async_rst_maddr", bus.m_addr, 32'd0);
    chk("async_rst_istall", bus.i_stall, 1'b1);
    chk("async_rst_idout", bus.i_dout, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    serve(40, 1);
    chk("post_rst_cyc", done_cyc[0], 9);
    chk("post_rst_dat", done_dat[0], 32'h1000_0011);
    gap("post_rst_rel_mcs");

    // Both ports requesting continuously for 4 grants, from reset
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_lat = 2;
    keep_cs = 1'b1;
    bus.d_cs = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    bus.i_cs = 1'b1; bus.i_addr = 32'h20;
    serve(80, 4);
    keep_cs = 1'b0;
    bus.d_cs = 1'b0; bus.i_cs = 1'b0;
`ifdef ARB_RR_EN
    chk("order_0", done_port[0], 1);
    chk("order_1", done_port[1], 0);
    chk("order_2", done_port[2], 1);
    chk("order_3", done_port[3], 0);
`else
    chk("order_0", done_port[0], 1);
    chk("order_1", done_port[1], 1);
    chk("order_2", done_port[2], 1);
    chk("order_3", done_port[3], 1);
`endif
    chk("order_d_dat", done_dat[0], 32'h1000_0044);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
